// File: rtl/key_conditioner_if.sv
// Key bus between the raw board buttons and the conditioned key outputs.
// The slave side is the conditioner; the master side is whoever drives the buttons.
interface key_conditioner_if #(
    parameter int NKEYS = 4
);
    logic [NKEYS-1:0] keys_raw;
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] keys_press;
    logic [NKEYS-1:0] keys_release;

    modport master (
        output keys_raw,
        input  keys,
        input  keys_press,
        input  keys_release
    );

    modport slave (
        input  keys_raw,
        output keys,
        output keys_press,
        output keys_release
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer and press/release strobe generator.
// Optional auto-repeat of press strobes is compiled in with KEY_CONDITIONER_REPEAT_EN.
module key_conditioner #(
    parameter int NKEYS           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic               clk,
    input  logic               reset,
    key_conditioner_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
            $error("key_conditioner: illegal parameter value");
        end
    endgenerate

    logic [NKEYS-1:0] r_s1;
    logic [NKEYS-1:0] r_s2;
    logic [NKEYS-1:0] r_keys;
    logic [NKEYS-1:0] r_press;
    logic [NKEYS-1:0] r_release;
    logic [CW-1:0]    r_cnt [NKEYS];

    logic [NKEYS-1:0] w_accept;
    logic [NKEYS-1:0] w_rise;
    logic [NKEYS-1:0] w_fall;
    logic [NKEYS-1:0] w_repeat;

    // A change is accepted when the synchronized level has differed for the full window.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NKEYS; i++) begin
            w_accept[i] = (r_s2[i] != r_keys[i]) && (r_cnt[i] == C_LAST);
        end
        w_rise = w_accept & ~r_keys;
        w_fall = w_accept & r_keys;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_keys    <= '0;
            r_release <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= bus.keys_raw;
            r_s2      <= r_s1;
            r_release <= w_fall;
            for (int i = 0; i < NKEYS; i++) begin
                if (r_s2[i] == r_keys[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_keys[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] R_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]    r_repCnt [NKEYS];
    logic [NKEYS-1:0] r_repSeen;

    // r_repSeen marks that the initial delay has elapsed and the shorter period now applies.
    always_comb begin
        w_repeat = '0;
        for (int i = 0; i < NKEYS; i++) begin
            w_repeat[i] = r_keys[i] && !w_accept[i] &&
                          (r_repSeen[i] ? (r_repCnt[i] == R_PERIOD_LAST)
                                        : (r_repCnt[i] == R_DELAY_LAST));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_repSeen <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                r_repCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (!r_keys[i] || w_accept[i]) begin
                    r_repCnt[i]  <= '0;
                    r_repSeen[i] <= 1'b0;
                end else if (w_repeat[i]) begin
                    r_repCnt[i]  <= '0;
                    r_repSeen[i] <= 1'b1;
                end else begin
                    r_repCnt[i] <= r_repCnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign w_repeat = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press <= '0;
        end else begin
            r_press <= w_rise | w_repeat;
        end
    end

    assign bus.keys         = r_keys;
    assign bus.keys_press   = r_press;
    assign bus.keys_release = r_release;
endmodule
